// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-0 initiator.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_CHAIN,
    ST_HOLD,
    ST_GAP
  } spi_state_e;

  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  // Smallest half-period that still covers the slave's IOB input flop plus our MISO sync.
  localparam int unsigned SPI_MIN_CLK_DIV = 4;

endpackage

// File: rtl/spi_clk_div.sv
// Down-counting interval timer: load a cycle count, tick on the last enabled cycle.
module spi_clk_div #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             sysclk,
  input  logic             spi_rst_ni,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // A state loaded with N lasts exactly N cycles: tick fires while the count reads 1.
  assign tick = en && (cnt_q == CNT_W'(1));

  always_ff @(posedge sysclk or negedge spi_rst_ni) begin
    if (!spi_rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 initiator: one command word per frame, optional CS_N chaining across words.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2,
  parameter int unsigned CS_IDLE  = 2
) (
  input  logic              sysclk,
  input  logic              spi_rst_ni,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              cmd_last,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              o_sclk,
  output logic              o_cs_n,
  output logic              o_mosi,
  input  logic              i_miso
);

  localparam int unsigned DIV_EFF = (CLK_DIV < SPI_MIN_CLK_DIV) ? SPI_MIN_CLK_DIV : CLK_DIV;
  localparam int unsigned MAX_A   = (DIV_EFF > CS_SETUP) ? DIV_EFF : CS_SETUP;
  localparam int unsigned MAX_B   = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
  localparam int unsigned MAX_T   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W   = $clog2(MAX_T + 1);
  localparam int unsigned BIT_W   = $clog2(DATA_W + 1);

  spi_state_e        state_q, state_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              last_q, last_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              sclk_q, sclk_d;
  logic              cs_n_q, cs_n_d;
  logic              mosi_q, mosi_d;
  logic              miso_s1_q, miso_s2_q;

  logic              accept;
  logic              div_load;
  logic              div_en;
  logic              div_tick;
  logic [CNT_W-1:0]  div_load_val;
  logic [DATA_W-1:0] rx_shifted;

  assign accept     = cmd_valid && cmd_ready_q;
  assign rx_shifted = {rx_q[DATA_W-2:0], miso_s2_q};

  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    rsp_data_d  = rsp_data_q;
    bit_d       = bit_q;
    last_d      = last_q;
    mosi_d      = mosi_q;
    rsp_valid_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_CHAIN: begin
        if (accept) begin
          tx_d    = cmd_data;
          rx_d    = '0;
          bit_d   = '0;
          last_d  = cmd_last;
          mosi_d  = cmd_data[DATA_W-1];
          state_d = (state_q == ST_IDLE) ? ST_SETUP : ST_SHIFT_LO;
        end
      end
      ST_SETUP: begin
        if (div_tick) state_d = ST_SHIFT_LO;
      end
      ST_SHIFT_LO: begin
        if (div_tick) state_d = ST_SHIFT_HI;
      end
      ST_SHIFT_HI: begin
        // MISO is taken on the last high cycle so the slave's IOB plus our sync have settled.
        if (div_tick) begin
          rx_d  = rx_shifted;
          bit_d = bit_q + BIT_W'(1);
          if (bit_q == BIT_W'(DATA_W - 1)) begin
            rsp_data_d  = rx_shifted;
            rsp_valid_d = 1'b1;
            state_d     = last_q ? ST_HOLD : ST_CHAIN;
          end else begin
            tx_d    = tx_q << 1;
            mosi_d  = tx_q[DATA_W-2];
            state_d = ST_SHIFT_LO;
          end
        end
      end
      ST_HOLD: begin
        if (div_tick) begin
          mosi_d  = 1'b0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (div_tick) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pins and ready are registered from the next state so they align with the state flop.
  always_comb begin
    cmd_ready_d  = (state_d == ST_IDLE) || (state_d == ST_CHAIN);
    cs_n_d       = (state_d == ST_IDLE) || (state_d == ST_GAP);
    sclk_d       = (state_d == ST_SHIFT_HI) ^ SPI_CPOL;
    div_load     = (state_d != state_q);
    div_en       = (state_q != ST_IDLE) && (state_q != ST_CHAIN);
    div_load_val = '0;
    case (state_d)
      ST_SETUP:                 div_load_val = CNT_W'(CS_SETUP);
      ST_SHIFT_LO, ST_SHIFT_HI: div_load_val = CNT_W'(DIV_EFF);
      ST_HOLD:                  div_load_val = CNT_W'(CS_HOLD);
      ST_GAP:                   div_load_val = CNT_W'(CS_IDLE);
      default:                  div_load_val = '0;
    endcase
  end

  spi_clk_div #(
    .CNT_W (CNT_W)
  ) u_clk_div (
    .sysclk     (sysclk),
    .spi_rst_ni (spi_rst_ni),
    .load       (div_load),
    .en         (div_en),
    .load_val   (div_load_val),
    .tick       (div_tick)
  );

  always_ff @(posedge sysclk or negedge spi_rst_ni) begin
    if (!spi_rst_ni) begin
      state_q     <= ST_IDLE;
      tx_q        <= '0;
      rx_q        <= '0;
      rsp_data_q  <= '0;
      bit_q       <= '0;
      last_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b0;
      sclk_q      <= SPI_CPOL;
      cs_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      miso_s1_q   <= 1'b0;
      miso_s2_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      rsp_data_q  <= rsp_data_d;
      bit_q       <= bit_d;
      last_q      <= last_d;
      rsp_valid_q <= rsp_valid_d;
      cmd_ready_q <= cmd_ready_d;
      sclk_q      <= sclk_d;
      cs_n_q      <= cs_n_d;
      mosi_q      <= mosi_d;
      miso_s1_q   <= i_miso;
      miso_s2_q   <= miso_s1_q;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != ST_IDLE);
  assign o_sclk    = sclk_q;
  assign o_cs_n    = cs_n_q;
  assign o_mosi    = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl with loopback and mode-0 slave MISO sources.
module tb_spi_master_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned CS_IDLE_T = 2;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic          sysclk = 1'b0;
  logic          spi_rst_ni = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [DW-1:0] cmd_data = '0;
  logic          cmd_last = 1'b0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          busy;
  logic          o_sclk, o_cs_n, o_mosi, i_miso;

  spi_master_ctrl #(
    .DATA_W  (DW),
    .CLK_DIV (4)
  ) dut (
    .sysclk     (sysclk),
    .spi_rst_ni (spi_rst_ni),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_data   (cmd_data),
    .cmd_last   (cmd_last),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .busy       (busy),
    .o_sclk     (o_sclk),
    .o_cs_n     (o_cs_n),
    .o_mosi     (o_mosi),
    .i_miso     (i_miso)
  );

  always #5 sysclk = ~sysclk;

  int checks = 0;
  int errors = 0;

  // MISO sources: 0 = MOSI looped through two flops, 1 = mode-0 slave model.
  logic          mode = 1'b0;
  logic [1:0]    lb_pipe = '0;
  logic [1:0]    sl_pipe = '0;
  logic [DW-1:0] slave_word = '0;
  logic [DW-1:0] sl_rx = '0;
  logic          sl_miso = 1'b0;
  logic          sl_sclk_d1 = 1'b0;
  int            sl_idx = 0;

  assign i_miso = mode ? sl_pipe[1] : lb_pipe[1];

  always @(posedge sysclk) begin
    lb_pipe    <= {lb_pipe[0], o_mosi};
    sl_pipe    <= {sl_pipe[0], sl_miso};
    sl_sclk_d1 <= o_sclk;
    if (o_cs_n) begin
      sl_idx  <= 0;
      sl_miso <= slave_word[DW-1];
    end else begin
      if (o_sclk && !sl_sclk_d1) sl_rx <= {sl_rx[DW-2:0], o_mosi};
      if (!o_sclk && sl_sclk_d1) begin
        sl_idx <= sl_idx + 1;
        if (sl_idx < DW - 1) sl_miso <= slave_word[DW-2-sl_idx];
      end
    end
  end

  // Monitor and scoreboard, sampled on the falling edge.
  exp_t exp_q[$];
  int   rises = 0, accepts = 0, rsp_cnt = 0, cs_falls = 0;
  int   cs_low_run = 0, cs_high_run = 0, last_low = 0, last_gap = 0;
  int   mosi_viol = 0, ready_viol = 0;
  logic in_hold = 1'b0;
  logic p_sclk = 1'b0, p_mosi = 1'b0, p_cs = 1'b1;

  always @(negedge sysclk) begin
    exp_t e;
    if (spi_rst_ni) begin
      if (o_sclk && !p_sclk) rises++;
      if (o_sclk && (o_mosi !== p_mosi)) mosi_viol++;
      if (cmd_valid && cmd_ready) begin
        accepts++;
        e.data = mode ? slave_word : cmd_data;
        e.last = cmd_last;
        exp_q.push_back(e);
      end
      if (rsp_valid) begin
        rsp_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: got rsp_valid with data %h, no word outstanding", rsp_data);
        end else begin
          e = exp_q.pop_front();
          in_hold = e.last;
          if (rsp_data !== e.data) begin
            errors++;
            $display("FAIL rsp_data: got %h expected %h", rsp_data, e.data);
          end
        end
      end
      if (!o_cs_n) begin
        if (p_cs) begin
          last_gap = cs_high_run;
          cs_low_run = 0;
          cs_falls++;
        end
        cs_low_run++;
        cs_high_run = 0;
      end else begin
        if (!p_cs) last_low = cs_low_run;
        cs_high_run++;
      end
      if (busy && o_cs_n && cmd_ready) ready_viol++;
      if (in_hold && !o_cs_n && cmd_ready) ready_viol++;
      if (o_cs_n) in_hold = 1'b0;
    end
    p_sclk = o_sclk;
    p_mosi = o_mosi;
    p_cs   = o_cs_n;
  end

  task automatic send(input logic [DW-1:0] d, input logic l);
    int n;
    @(posedge sysclk);
    #1;
    cmd_valid = 1'b1;
    cmd_data  = d;
    cmd_last  = l;
    n = 0;
    do begin
      @(negedge sysclk);
      n++;
    end while (!cmd_ready && n < 2000);
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
    end
    @(posedge sysclk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge sysclk);
      n++;
    end while (busy && n < 2000);
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy, n);
    end
    repeat (2) @(negedge sysclk);
  endtask

  task automatic check_val(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge sysclk);
    checks += 7;
    if (o_sclk !== 1'b0)    begin errors++; $display("FAIL rst_sclk: got %b expected 0", o_sclk); end
    if (o_cs_n !== 1'b1)    begin errors++; $display("FAIL rst_cs_n: got %b expected 1", o_cs_n); end
    if (o_mosi !== 1'b0)    begin errors++; $display("FAIL rst_mosi: got %b expected 0", o_mosi); end
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", cmd_ready); end
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid); end
    if (rsp_data !== '0)    begin errors++; $display("FAIL rst_rsp_data: got %h expected 00", rsp_data); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    spi_rst_ni = 1'b1;
    repeat (2) @(negedge sysclk);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_loopback();
    int r0, q0;
    mode = 1'b0;
    r0 = rises;
    q0 = rsp_cnt;
    send(8'hA5, 1'b1);
    wait_idle();
    check_val("lb_rises", rises - r0, 8);
    check_val("lb_cs_low", last_low, 2 + 64 + 2);
    check_val("lb_rsp_count", rsp_cnt - q0, 1);
    checks++;
    if (rsp_data !== 8'hA5) begin errors++; $display("FAIL lb_rsp_held: got %h expected a5", rsp_data); end
  endtask

  task automatic test_slave();
    int v0;
    mode = 1'b1;
    slave_word = 8'h3C;
    v0 = mosi_viol;
    send(8'hC3, 1'b1);
    wait_idle();
    checks++;
    if (sl_rx !== 8'hC3) begin errors++; $display("FAIL slave_mosi_word: got %h expected c3", sl_rx); end
    check_val("mosi_stable", mosi_viol - v0, 0);
    checks++;
    if (rsp_data !== 8'h3C) begin errors++; $display("FAIL slave_rsp: got %h expected 3c", rsp_data); end
    mode = 1'b0;
  endtask

  task automatic test_chain();
    int f0, r0, q0;
    f0 = cs_falls;
    r0 = rises;
    q0 = rsp_cnt;
    send(8'h81, 1'b0);
    send(8'h7E, 1'b1);
    wait_idle();
    check_val("chain_cs_falls", cs_falls - f0, 1);
    check_val("chain_rises", rises - r0, 16);
    check_val("chain_rsp_count", rsp_cnt - q0, 2);
    check_val("chain_cs_low", last_low, 2 + 64 + 1 + 64 + 2);
  endtask

  task automatic test_back_to_back();
    int f0, q0, v0;
    f0 = cs_falls;
    q0 = rsp_cnt;
    v0 = ready_viol;
    send(8'h33, 1'b1);
    send(8'hCC, 1'b1);
    wait_idle();
    check_val("b2b_cs_falls", cs_falls - f0, 2);
    checks++;
    if (last_gap < CS_IDLE_T) begin
      errors++;
      $display("FAIL b2b_gap: got %0d cycles expected at least %0d", last_gap, CS_IDLE_T);
    end
    check_val("b2b_ready_in_hold_gap", ready_viol - v0, 0);
    check_val("b2b_rsp_count", rsp_cnt - q0, 2);
  endtask

  task automatic test_reset_mid();
    int n, q0;
    mode = 1'b0;
    @(posedge sysclk);
    #1;
    cmd_valid = 1'b1;
    cmd_data  = 8'hFF;
    cmd_last  = 1'b1;
    n = 0;
    do begin
      @(negedge sysclk);
      n++;
      if (cmd_ready) begin
        @(posedge sysclk);
        #1;
        cmd_valid = 1'b0;
      end
    end while (!(o_sclk && cmd_valid == 1'b0 && n > 20) && n < 500);
    @(negedge sysclk);
    checks++;
    if (o_sclk !== 1'b1) begin errors++; $display("FAIL mid_reach_high: got sclk %b expected 1", o_sclk); end
    #1;
    spi_rst_ni = 1'b0;
    #1;
    checks += 5;
    if (o_sclk !== 1'b0)    begin errors++; $display("FAIL mid_rst_sclk: got %b expected 0", o_sclk); end
    if (o_cs_n !== 1'b1)    begin errors++; $display("FAIL mid_rst_cs_n: got %b expected 1", o_cs_n); end
    if (o_mosi !== 1'b0)    begin errors++; $display("FAIL mid_rst_mosi: got %b expected 0", o_mosi); end
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_rsp_valid: got %b expected 0", rsp_valid); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
    exp_q.delete();
    repeat (3) @(negedge sysclk);
    spi_rst_ni = 1'b1;
    q0 = rsp_cnt;
    send(8'h5A, 1'b1);
    wait_idle();
    check_val("post_rst_rsp_count", rsp_cnt - q0, 1);
    checks++;
    if (rsp_data !== 8'h5A) begin errors++; $display("FAIL post_rst_rsp: got %h expected 5a", rsp_data); end
  endtask

  task automatic test_hold_valid();
    int a0, r0, q0, n;
    a0 = accepts;
    r0 = rises;
    q0 = rsp_cnt;
    @(posedge sysclk);
    #1;
    cmd_valid = 1'b1;
    cmd_data  = 8'h96;
    cmd_last  = 1'b1;
    n = 0;
    while (accepts < a0 + 2 && n < 1000) begin
      @(negedge sysclk);
      n++;
    end
    @(posedge sysclk);
    #1;
    cmd_valid = 1'b0;
    wait_idle();
    repeat (20) @(negedge sysclk);
    check_val("hold_accepts", accepts - a0, 2);
    check_val("hold_rises", rises - r0, 16);
    check_val("hold_rsp_count", rsp_cnt - q0, 2);
    check_val("hold_outstanding", exp_q.size(), 0);
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_slave();
    test_chain();
    test_back_to_back();
    test_reset_mid();
    test_hold_valid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
